stream_demux_1to2: RTL and testbench

//   Routes one valid/ready data stream to one of two output streams (A or B): the

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_out_slot.sv | 47 ++++
 rtl/stream_demux_1to2.sv | 136 +++++++++++++
 tb/tb_stream_demux_1to2.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and port encodings for the 1:2 stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Packet routing state: IDLE samples sel on a new packet, LOCKED holds it
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } demux_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_out_slot
// Description : One-entry valid/ready output register carrying data and last.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_last;

    // A load wins over a drain so a simultaneous load/drain keeps the slot full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
            r_last  <= load_last;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;

endmodule : demux_out_slot
`default_nettype wire

// File: rtl/stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1to2
// Description : Routes a valid/ready packet stream to port A or B, per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1to2
    import demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     input_data,
    input  logic                 input_valid,
    input  logic                 input_last,
    output logic                 input_ready,
    input  logic                 sel,
    output logic [WIDTH-1:0]     out_a,
    output logic                 out_a_valid,
    output logic                 out_a_last,
    input  logic                 out_a_ready,
    output logic [WIDTH-1:0]     out_b,
    output logic                 out_b_valid,
    output logic                 out_b_last,
    input  logic                 out_b_ready,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    demux_state_t         r_state;
    logic                 r_route;
    logic [CNT_WIDTH-1:0] r_cnt_a;
    logic [CNT_WIDTH-1:0] r_cnt_b;

    logic w_route;
    logic w_ready;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;
    logic w_hs_a;
    logic w_hs_b;

    assign w_route = (r_state == IDLE) ? sel : r_route;

    // Ready looks only at the selected slot; the other port may stay blocked
    always_comb begin
        w_ready = 1'b0;
        if (w_route == PORT_A) begin
            w_ready = !out_a_valid || out_a_ready;
        end else begin
            w_ready = !out_b_valid || out_b_ready;
        end
    end

    assign input_ready = rst_n && w_ready;
    assign w_accept    = input_valid && input_ready;
    assign w_load_a    = w_accept && (w_route == PORT_A);
    assign w_load_b    = w_accept && (w_route == PORT_B);
    assign w_hs_a      = out_a_valid && out_a_ready;
    assign w_hs_b      = out_b_valid && out_b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_route <= PORT_A;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && !input_last) begin
                        r_state <= LOCKED;
                        r_route <= sel;
                    end
                end
                LOCKED: begin
                    if (w_accept && input_last) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_hs_a) begin
                r_cnt_a <= r_cnt_a + C_CNT_ONE;
            end
            if (w_hs_b) begin
                r_cnt_b <= r_cnt_b + C_CNT_ONE;
            end
        end
    end

    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;

    demux_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load_a),
        .load_data (input_data),
        .load_last (input_last),
        .out_data  (out_a),
        .out_valid (out_a_valid),
        .out_last  (out_a_last),
        .out_ready (out_a_ready)
    );

    demux_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load_b),
        .load_data (input_data),
        .load_last (input_last),
        .out_data  (out_b),
        .out_valid (out_b_valid),
        .out_last  (out_b_last),
        .out_ready (out_b_ready)
    );

endmodule : stream_demux_1to2
`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1to2
// Description : Self-checking bench for stream_demux_1to2 against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1to2;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [WIDTH-1:0]     input_data = '0;
    logic                 input_valid = 1'b0;
    logic                 input_last = 1'b0;
    logic                 input_ready;
    logic                 sel = 1'b0;
    logic [WIDTH-1:0]     out_a;
    logic                 out_a_valid;
    logic                 out_a_last;
    logic                 out_a_ready = 1'b1;
    logic [WIDTH-1:0]     out_b;
    logic                 out_b_valid;
    logic                 out_b_last;
    logic                 out_b_ready = 1'b1;
    logic [CNT_WIDTH-1:0] cnt_a;
    logic [CNT_WIDTH-1:0] cnt_b;

    always #5 clk = ~clk;

    stream_demux_1to2 #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_data  (input_data),
        .input_valid (input_valid),
        .input_last  (input_last),
        .input_ready (input_ready),
        .sel         (sel),
        .out_a       (out_a),
        .out_a_valid (out_a_valid),
        .out_a_last  (out_a_last),
        .out_a_ready (out_a_ready),
        .out_b       (out_b),
        .out_b_valid (out_b_valid),
        .out_b_last  (out_b_last),
        .out_b_ready (out_b_ready),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per-port queues of {last, data} in delivery order
    logic [WIDTH:0]       q_a[$];
    logic [WIDTH:0]       q_b[$];
    logic [CNT_WIDTH-1:0] m_cnt_a = '0;
    logic [CNT_WIDTH-1:0] m_cnt_b = '0;
    bit                   m_in_pkt = 1'b0;
    bit                   m_lock_route = 1'b0;
    bit                   acc_flag = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_a.delete();
        q_b.delete();
        m_cnt_a      = '0;
        m_cnt_b      = '0;
        m_in_pkt     = 1'b0;
        m_lock_route = 1'b0;
    endtask

    // One clock: compare at negedge, advance model, return just after posedge
    task automatic tick();
        bit r;
        bit rdy;
        @(negedge clk);
        r   = m_in_pkt ? m_lock_route : sel;
        rdy = (r == 1'b0) ? (q_a.size() == 0 || out_a_ready) : (q_b.size() == 0 || out_b_ready);
        check_val("in_ready", {31'b0, input_ready}, {31'b0, rdy});
        check_val("a_valid", {31'b0, out_a_valid}, {31'b0, q_a.size() != 0});
        check_val("b_valid", {31'b0, out_b_valid}, {31'b0, q_b.size() != 0});
        if (q_a.size() != 0) begin
            check_val("a_data", {24'b0, out_a}, {24'b0, q_a[0][WIDTH-1:0]});
            check_val("a_last", {31'b0, out_a_last}, {31'b0, q_a[0][WIDTH]});
        end
        if (q_b.size() != 0) begin
            check_val("b_data", {24'b0, out_b}, {24'b0, q_b[0][WIDTH-1:0]});
            check_val("b_last", {31'b0, out_b_last}, {31'b0, q_b[0][WIDTH]});
        end
        check_val("cnt_a", {28'b0, cnt_a}, {28'b0, m_cnt_a});
        check_val("cnt_b", {28'b0, cnt_b}, {28'b0, m_cnt_b});
        if (q_a.size() != 0 && out_a_ready) begin
            void'(q_a.pop_front());
            m_cnt_a = m_cnt_a + 1'b1;
        end
        if (q_b.size() != 0 && out_b_ready) begin
            void'(q_b.pop_front());
            m_cnt_b = m_cnt_b + 1'b1;
        end
        acc_flag = input_valid && rdy;
        if (acc_flag) begin
            if (r == 1'b0) q_a.push_back({input_last, input_data});
            else           q_b.push_back({input_last, input_data});
            if (!m_in_pkt && !input_last) begin
                m_in_pkt     = 1'b1;
                m_lock_route = sel;
            end else if (m_in_pkt && input_last) begin
                m_in_pkt = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_val("rst_in_ready", {31'b0, input_ready}, 32'd0);
        check_val("rst_a_valid", {31'b0, out_a_valid}, 32'd0);
        check_val("rst_b_valid", {31'b0, out_b_valid}, 32'd0);
        check_val("rst_cnt_a", {28'b0, cnt_a}, 32'd0);
        check_val("rst_cnt_b", {28'b0, cnt_b}, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input bit s, input bit l, output int n);
        n = 0;
        input_valid = 1'b1;
        input_data  = d;
        sel         = s;
        input_last  = l;
        do begin
            tick();
            n++;
        end while (!acc_flag && n < 50);
        if (!acc_flag) check_val("send_timeout", 32'd0, 32'd1);
        input_valid = 1'b0;
    endtask

    initial begin
        int n;
        int cyc;
        #1;
        // Reset and first cycle after
        do_reset();
        repeat (2) tick();
        // Single beat to A
        send(8'h3C, 1'b0, 1'b1, n);
        repeat (2) tick();
        // Packet lock: second beat follows B despite sel=0
        send(8'h11, 1'b1, 1'b0, n);
        send(8'h22, 1'b0, 1'b1, n);
        send(8'h33, 1'b0, 1'b1, n);
        repeat (2) tick();
        // Reset mid-packet, next packet routed by fresh sel
        send(8'h11, 1'b1, 1'b0, n);
        do_reset();
        send(8'h33, 1'b0, 1'b1, n);
        repeat (2) tick();
        // Backpressure on B
        out_b_ready = 1'b0;
        send(8'hAA, 1'b1, 1'b0, n);
        input_valid = 1'b1;
        input_data  = 8'hBB;
        sel         = 1'b1;
        input_last  = 1'b1;
        repeat (3) tick();
        out_b_ready = 1'b1;
        send(8'hBB, 1'b1, 1'b1, n);
        repeat (3) tick();
        // Throughput: 16 back-to-back single-beat packets, alternating ports
        do_reset();
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            send(8'(i + 8'h40), 1'(i % 2), 1'b1, n);
            cyc += n;
        end
        check_val("throughput_cycles", cyc, 32'd16);
        repeat (2) tick();
        check_val("tput_cnt_a", {28'b0, cnt_a}, 32'd8);
        check_val("tput_cnt_b", {28'b0, cnt_b}, 32'd8);
        // Counter wrap: 17 beats to A
        do_reset();
        for (int i = 0; i < 17; i++) send(8'(i), 1'b0, 1'b1, n);
        repeat (2) tick();
        check_val("wrap_cnt_a", {28'b0, cnt_a}, 32'd1);
        check_val("wrap_cnt_b", {28'b0, cnt_b}, 32'd0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            input_valid = 1'($urandom_range(0, 3) != 0);
            input_data  = 8'($urandom);
            input_last  = 1'($urandom_range(0, 2) == 0);
            sel         = 1'($urandom);
            out_a_ready = 1'($urandom_range(0, 3) != 0);
            out_b_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        input_valid = 1'b0;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        repeat (3) tick();
        check_val("drain_a_empty", q_a.size(), 32'd0);
        check_val("drain_b_empty", q_b.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_demux_1to2
`default_nettype wire
